// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Registered issue/capture stage around a combinational N-bit ALU. One command is
// accepted per in_valid/in_ready handshake. Its operands, mode and carry-in are held on
// the ALU inputs for one evaluation cycle. The ALU result is then captured and offered on
// an out_valid/out_ready handshake. A carry flag is kept for multi-word chained
// arithmetic, together with a zero flag and a count of completed operations.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      command handshake
//   in_A, in_B, in_Mode      command operands and ALU mode word
//   in_cin, in_chain         explicit carry-in, or use the stored carry flag instead
//   A, B, Mode, CB_in        registered ALU inputs
//   Result, CB_out           combinational ALU outputs
//   out_valid / out_ready    result handshake
//   out_Result, out_CB       captured result and carry/borrow
//   out_Z                    captured result was zero
//   op_count                 results accepted by the consumer, wraps at 8 bits
module alu_op_sequencer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_A,
    input  logic [N-1:0] in_B,
    input  logic [N-1:0] in_Mode,
    input  logic         in_cin,
    input  logic         in_chain,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] Mode,
    output logic         CB_in,
    input  logic [N-1:0] Result,
    input  logic         CB_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_Result,
    output logic         out_CB,
    output logic         out_Z,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] mode_q, mode_d;
    logic         cb_in_q, cb_in_d;
    logic [N-1:0] out_result_q, out_result_d;
    logic         out_cb_q, out_cb_d;
    logic         out_z_q, out_z_d;
    logic         carry_flag_q, carry_flag_d;
    logic [7:0]   op_count_q, op_count_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= '0;
            cb_in_q      <= 1'b0;
            out_result_q <= '0;
            out_cb_q     <= 1'b0;
            out_z_q      <= 1'b0;
            carry_flag_q <= 1'b0;
            op_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            cb_in_q      <= cb_in_d;
            out_result_q <= out_result_d;
            out_cb_q     <= out_cb_d;
            out_z_q      <= out_z_d;
            carry_flag_q <= carry_flag_d;
            op_count_q   <= op_count_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        mode_d       = mode_q;
        cb_in_d      = cb_in_q;
        out_result_d = out_result_q;
        out_cb_d     = out_cb_q;
        out_z_d      = out_z_q;
        carry_flag_d = carry_flag_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    mode_d  = in_Mode;
                    cb_in_d = in_chain ? carry_flag_q : in_cin;
                    state_d = StExec;
                end
            end
            StExec: begin
                out_result_d = Result;
                out_cb_d     = CB_out;
                out_z_d      = (Result == '0);
                // Next chained op sees this capture even when issued back-to-back
                carry_flag_d = CB_out;
                state_d      = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode state only, so no comb path from in_valid / out_ready
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StHold);
    end

    assign A          = a_q;
    assign B          = b_q;
    assign Mode       = mode_q;
    assign CB_in      = cb_in_q;
    assign out_Result = out_result_q;
    assign out_CB     = out_cb_q;
    assign out_Z      = out_z_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with an adder stub standing in for the ALU.
// Reference model: integer sum of operands and selected carry-in, a stored carry flag
// and an 8-bit count of accepted results.
module tb_alu_op_sequencer;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_A, in_B, in_Mode;
    logic         in_cin, in_chain;
    logic [N-1:0] A, B, Mode;
    logic         CB_in;
    logic [N-1:0] Result;
    logic         CB_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_Result;
    logic         out_CB;
    logic         out_Z;
    logic [7:0]   op_count;

    logic [N:0]   alu_sum;

    int           n_checks = 0;
    int           n_fail = 0;
    logic         model_carry;
    logic [7:0]   model_count;

    always #5 clk = ~clk;

    // ALU stub: Result = A + B + CB_in, CB_out = carry
    assign alu_sum = {1'b0, A} + {1'b0, B} + (N+1)'(CB_in);
    assign Result  = alu_sum[N-1:0];
    assign CB_out  = alu_sum[N];

    alu_op_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .in_Mode    (in_Mode),
        .in_cin     (in_cin),
        .in_chain   (in_chain),
        .A          (A),
        .B          (B),
        .Mode       (Mode),
        .CB_in      (CB_in),
        .Result     (Result),
        .CB_out     (CB_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_Result (out_Result),
        .out_CB     (out_CB),
        .out_Z      (out_Z),
        .op_count   (op_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one command, check capture, optionally stall the consumer (with a new command
    // pending on the input), or abort with reset while the result is held.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] mode, input logic cin, input logic chain,
                          input int stall, input bit abort);
        int          guard;
        int          sum;
        logic        exp_cbin;
        logic [N-1:0] exp_res;
        logic        exp_cb;

        @(negedge clk);
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        in_Mode  = mode;
        in_cin   = cin;
        in_chain = chain;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_cbin = chain ? model_carry : cin;
        sum      = int'(a) + int'(b) + int'(exp_cbin);
        exp_res  = N'(sum);
        exp_cb   = (sum >= (1 << N));
        check_eq("exec_A", 32'(A), 32'(a));
        check_eq("exec_B", 32'(B), 32'(b));
        check_eq("exec_Mode", 32'(Mode), 32'(mode));
        check_eq("exec_CB_in", 32'(CB_in), 32'(exp_cbin));
        check_eq("exec_in_ready", 32'(in_ready), 32'd0);
        check_eq("exec_out_valid", 32'(out_valid), 32'd0);
        out_ready = (stall == 0);

        @(posedge clk);
        #1;
        model_carry = exp_cb;
        check_eq("cap_out_valid", 32'(out_valid), 32'd1);
        check_eq("cap_out_Result", 32'(out_Result), 32'(exp_res));
        check_eq("cap_out_CB", 32'(out_CB), 32'(exp_cb));
        check_eq("cap_out_Z", 32'(out_Z), 32'(exp_res == '0));
        check_eq("cap_in_ready", 32'(in_ready), 32'd0);

        if (abort) begin
            #2;
            rst_n = 1'b0;
            #1;
            model_carry = 1'b0;
            check_eq("abort_out_valid", 32'(out_valid), 32'd0);
            check_eq("abort_in_ready", 32'(in_ready), 32'd1);
            check_eq("abort_op_count", 32'(op_count), 32'(model_count));
            check_eq("abort_out_Result", 32'(out_Result), 32'd0);
            check_eq("abort_A", 32'(A), 32'd0);
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 1'b1;
            return;
        end

        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_A     = N'($urandom);
            in_B     = N'($urandom);
            in_Mode  = N'($urandom);
            in_cin   = 1'($urandom);
            in_chain = 1'($urandom);
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_out_Result", 32'(out_Result), 32'(exp_res));
            check_eq("bp_out_CB", 32'(out_CB), 32'(exp_cb));
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_A_held", 32'(A), 32'(a));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        model_count = model_count + 8'd1;
        check_eq("done_out_valid", 32'(out_valid), 32'd0);
        check_eq("done_in_ready", 32'(in_ready), 32'd1);
        check_eq("done_op_count", 32'(op_count), 32'(model_count));
        check_eq("done_A_held", 32'(A), 32'(a));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        in_valid    = 1'b0;
        in_A        = '0;
        in_B        = '0;
        in_Mode     = '0;
        in_cin      = 1'b0;
        in_chain    = 1'b0;
        out_ready   = 1'b1;
        model_carry = 1'b0;
        model_count = 8'd0;

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_A", 32'(A), 32'd0);
        check_eq("rst_B", 32'(B), 32'd0);
        check_eq("rst_Mode", 32'(Mode), 32'd0);
        check_eq("rst_CB_in", 32'(CB_in), 32'd0);
        check_eq("rst_out_Result", 32'(out_Result), 32'd0);
        check_eq("rst_out_CB", 32'(out_CB), 32'd0);
        check_eq("rst_out_Z", 32'(out_Z), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while holding a carry-producing result, then a chained op sees carry 0
        run_op(4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 2, 1'b1);
        run_op(4'h5, 4'h6, 4'h0, 1'b1, 1'b1, 0, 1'b0);

        // Single op
        run_op(4'h3, 4'h4, 4'h0, 1'b0, 1'b0, 0, 1'b0);

        // Chained 8-bit add: 0x0F + 0x01
        run_op(4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        run_op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 0, 1'b0);

        // Back-pressure for 5 cycles with a new command pending
        run_op(4'h9, 4'hA, 4'h8, 1'b1, 1'b0, 5, 1'b0);

        // Random ops, enough to wrap op_count
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(N'($urandom), N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                   stall, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered issue/capture stage wrapped around the combinational N-bit modified ALU. It accepts one operation per valid/ready handshake and holds the operands, mode and carry-in stable on the ALU inputs for one full evaluation cycle. It then registers the ALU result and carry/borrow output and presents them on an output valid/ready handshake. It also keeps a carry flag for multi-word chained arithmetic, a zero flag, and a completed-operation counter.

## Interface
- N, 4: operand/result width; also the width of the Mode bus, must be >= 4 (Mode[3] selects the shifter path in the ALU)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  command present
- in_ready  output  1  sequencer can accept a command
- in_A, in_B  input  N  operands
- in_Mode  input  N  ALU mode word
- in_cin  input  1  explicit carry/borrow-in
- in_chain  input  1  1 = use stored carry flag as carry-in instead of in_cin
- A, B  output  N  registered operands to ALU
- Mode  output  N  registered mode to ALU
- CB_in  output  1  registered carry-in to ALU
- Result  input  N  ALU result
- CB_out  input  1  ALU carry/borrow-out
- out_valid  output  1  captured result available
- out_ready  input  1  consumer accepts result
- out_Result  output  N  captured result
- out_CB  output  1  captured carry/borrow
- out_Z  output  1  1 when captured result == 0
- op_count  output  8  number of results accepted by the consumer

## Operation
- The FSM has three states, IDLE, EXEC and HOLD. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge, register in_A -> A, in_B -> B and in_Mode -> Mode.
  - CB_in <= in_chain ? carry_flag : in_cin.
  - Go to EXEC.
- EXEC:
  - in_ready = 0. ALU inputs are held.
  - At the next edge, register Result -> out_Result, CB_out -> out_CB and (Result == 0) -> out_Z.
  - carry_flag <= CB_out. Go to HOLD.
- HOLD:
  - out_valid = 1 and in_ready = 0.
  - All out_* are held stable while out_valid && !out_ready.
  - On out_ready: increment op_count and go to IDLE.
- carry_flag:
  - It is internal and updates only on capture in EXEC.
  - It is never cleared by a non-chained op; only reset clears it.
- op_count: unsigned 8-bit, increments once per accepted result, and wraps from 255 to 0 with no flag.
- A, B, Mode and CB_in keep their last values outside IDLE-accept. They are not cleared after an op.
- in_* inputs are ignored whenever in_ready = 0. No command is lost or duplicated, because the upstream side must hold in_valid until it sees the handshake.

## Timing
- Reset (asynchronous, active-low; takes effect immediately, independent of clk):
  - State = IDLE.
  - A, B, Mode, CB_in, out_Result, out_CB, carry_flag and op_count = 0.
  - out_valid = 0, in_ready = 1, out_Z = 0.
- Reset asserted mid-operation (EXEC or HOLD) discards the op. op_count is not incremented.
- Latency:
  - Command accepted at edge t.
  - ALU inputs are valid after t.
  - Result is captured at edge t+1.
  - out_valid is high from t+1.
  - With out_ready tied 1, HOLD lasts exactly one cycle. in_ready returns high after edge t+2.
  - Maximum throughput is one op per 3 cycles.
- out_valid and in_ready are decoded from state only; there is no combinational path from in_valid or out_ready.
- Back-pressure: HOLD persists indefinitely while out_ready = 0. in_valid arriving during HOLD waits.
- A chained op uses the carry_flag captured by the immediately preceding completed op, including that op's capture when both are back-to-back.

## Test plan
Bench uses an ALU stub: Result = A + B + CB_in mod 2^N, CB_out = carry. N = 4.

- Reset check: assert rst_n = 0 mid-clock with no clock edge -> all outputs at their reset values immediately, in_ready = 1.
- Single op, out_ready = 1:
  - Stimulus: in_A = 4'h3, in_B = 4'h4, in_cin = 0, in_chain = 0.
  - Response: A = 3 and B = 4 one edge after accept; out_valid rises one edge later with out_Result = 7, out_CB = 0, out_Z = 0.
  - out_valid lasts 1 cycle and op_count = 1.
- Chained 8-bit add as two 4-bit ops:
  - Stimulus: op 1 is F + 1 with cin = 0; op 2 is 0 + 0 with in_chain = 1.
  - Response: op 1 gives out_Result = 0, out_CB = 1, out_Z = 1; op 2 drives CB_in = 1 and gives out_Result = 1, out_CB = 0.
- Back-pressure:
  - Stimulus: hold out_ready = 0 for 5 cycles while in_valid = 1 with new operands.
  - Response: out_Result and out_CB stay stable, in_ready = 0 throughout, and the new command is accepted only after out_ready handshake.
- Counter wrap: run 256 ops -> op_count goes 255 -> 0.
- Reset in HOLD: assert rst_n while out_valid = 1 -> out_valid = 0 immediately, op_count unchanged at 0, carry_flag = 0. A following chained op drives CB_in = 0.
